tl_sram_slave: RTL

TileLink-UL memory endpoint that sits directly downstream of the TL buffer stage on the uncached peripheral path and consumes its A-channel output. It accepts single-beat and burst Get, PutFullData and PutPartialData requests, and executes them against an internal synchronous-read, 64-bit-wide SRAM. It returns AccessAck or AccessAckData on the D channel into the buffer's D-channel input. Only one transaction is in flight at a time.

---
 rtl/tl_sram_slave.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/tl_sram_slave.sv
// TileLink-UL SRAM endpoint. It serves single-beat and burst Get/Put requests
// from a 64-bit synchronous-read array, with one transaction in flight at a time.
module tl_sram_slave #(
  parameter int DEPTH_WORDS = 1024,
  parameter int MAX_SIZE    = 6
) (
  input  logic        clock,
  input  logic        reset,
  output logic        auto_in_a_ready,
  input  logic        auto_in_a_valid,
  input  logic [2:0]  auto_in_a_bits_opcode,
  input  logic [2:0]  auto_in_a_bits_size,
  input  logic        auto_in_a_bits_source,
  input  logic [35:0] auto_in_a_bits_address,
  input  logic [7:0]  auto_in_a_bits_mask,
  input  logic [63:0] auto_in_a_bits_data,
  input  logic        auto_in_d_ready,
  output logic        auto_in_d_valid,
  output logic [2:0]  auto_in_d_bits_opcode,
  output logic [2:0]  auto_in_d_bits_size,
  output logic        auto_in_d_bits_source,
  output logic [63:0] auto_in_d_bits_data
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = (MAX_SIZE > 3) ? (MAX_SIZE - 2) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_ACK   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   last_q, last_d;
  logic [IW-1:0]   base_q, base_d;
  logic [2:0]      size_q, size_d;
  logic            source_q, source_d;
  logic            kill_q, kill_d;
  logic            d_valid_q, d_valid_d;
  logic [2:0]      d_opcode_q, d_opcode_d;
  logic [63:0]     rdata_q;
  logic [63:0]     mem_q [DEPTH_WORDS];

  logic            a_fire_s, d_fire_s;
  logic            req_get_s, req_legal_put_s;
  logic [2:0]      eff_size_s;
  logic [CW-1:0]   req_last_s;
  logic [IW-1:0]   req_base_s;
  logic            ren_s, clr_s, we_s;
  logic [IW-1:0]   raddr_s, waddr_s;
  logic [7:0]      wmask_s;
  logic            unused_addr_s;

  assign auto_in_a_ready = reset & ((state_q == S_IDLE) | (state_q == S_WRITE));
  assign a_fire_s        = auto_in_a_ready & auto_in_a_valid;
  assign d_fire_s        = d_valid_q & auto_in_d_ready;
  assign req_get_s       = (auto_in_a_bits_opcode == 3'd4);
  assign req_legal_put_s = (auto_in_a_bits_opcode == 3'd0) | (auto_in_a_bits_opcode == 3'd1);
  assign req_base_s      = auto_in_a_bits_address[IW+2:3] & ~IW'(req_last_s);
  assign unused_addr_s   = ^{auto_in_a_bits_address[35:IW+3], auto_in_a_bits_address[2:0]};

  assign auto_in_d_valid       = d_valid_q;
  assign auto_in_d_bits_opcode = d_opcode_q;
  assign auto_in_d_bits_size   = size_q;
  assign auto_in_d_bits_source = source_q;
  assign auto_in_d_bits_data   = rdata_q;

  // Last beat index of the incoming request; oversize requests clamp to MAX_SIZE.
  always_comb begin
    eff_size_s = (auto_in_a_bits_size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : auto_in_a_bits_size;
    if (eff_size_s > 3'd3) begin
      req_last_s = CW'((32'd1 << (eff_size_s - 3'd3)) - 32'd1);
    end else begin
      req_last_s = {CW{1'b0}};
    end
  end

  // Next-state, RAM port controls and D-channel register updates.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    base_d     = base_q;
    size_d     = size_q;
    source_d   = source_q;
    kill_d     = kill_q;
    d_valid_d  = d_valid_q;
    d_opcode_d = d_opcode_q;
    ren_s      = 1'b0;
    raddr_s    = base_q;
    clr_s      = 1'b0;
    we_s       = 1'b0;
    waddr_s    = base_q;
    wmask_s    = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (a_fire_s) begin
          size_d   = auto_in_a_bits_size;
          source_d = auto_in_a_bits_source;
          base_d   = req_base_s;
          last_d   = req_last_s;
          kill_d   = ~req_legal_put_s;
          if (req_get_s) begin
            ren_s      = 1'b1;
            raddr_s    = req_base_s;
            cnt_d      = {CW{1'b0}};
            state_d    = S_READ;
            d_valid_d  = 1'b1;
            d_opcode_d = 3'd1;
          end else begin
            we_s    = 1'b1;
            waddr_s = req_base_s;
            wmask_s = req_legal_put_s ? auto_in_a_bits_mask : 8'h00;
            if (req_last_s == {CW{1'b0}}) begin
              state_d    = S_ACK;
              d_valid_d  = 1'b1;
              d_opcode_d = 3'd0;
              clr_s      = 1'b1;
              cnt_d      = {CW{1'b0}};
            end else begin
              state_d = S_WRITE;
              cnt_d   = CW'(1);
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (d_fire_s) begin
          if (cnt_q == last_q) begin
            state_d   = S_IDLE;
            d_valid_d = 1'b0;
            cnt_d     = {CW{1'b0}};
          end else begin
            ren_s   = 1'b1;
            raddr_s = base_q + IW'(cnt_q + CW'(1));
            cnt_d   = cnt_q + CW'(1);
          end
        end else begin
          state_d = S_READ;
        end
      end
      S_WRITE: begin
        if (a_fire_s) begin
          we_s    = 1'b1;
          waddr_s = base_q + IW'(cnt_q);
          wmask_s = kill_q ? 8'h00 : auto_in_a_bits_mask;
          if (cnt_q == last_q) begin
            state_d    = S_ACK;
            d_valid_d  = 1'b1;
            d_opcode_d = 3'd0;
            clr_s      = 1'b1;
            cnt_d      = {CW{1'b0}};
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = S_WRITE;
        end
      end
      S_ACK: begin
        if (d_fire_s) begin
          state_d   = S_IDLE;
          d_valid_d = 1'b0;
        end else begin
          state_d = S_ACK;
        end
      end
      default: begin
        state_d   = S_IDLE;
        d_valid_d = 1'b0;
        cnt_d     = {CW{1'b0}};
      end
    endcase
  end

  // Control and D-channel state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CW{1'b0}};
      last_q     <= {CW{1'b0}};
      base_q     <= {IW{1'b0}};
      size_q     <= 3'd0;
      source_q   <= 1'b0;
      kill_q     <= 1'b0;
      d_valid_q  <= 1'b0;
      d_opcode_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      base_q     <= base_d;
      size_q     <= size_d;
      source_q   <= source_d;
      kill_q     <= kill_d;
      d_valid_q  <= d_valid_d;
      d_opcode_q <= d_opcode_d;
    end
  end

  // Synchronous read port; the register only moves on an enabled read or ack clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata_q <= 64'd0;
    end else if (ren_s) begin
      rdata_q <= mem_q[raddr_s];
    end else if (clr_s) begin
      rdata_q <= 64'd0;
    end else begin
      rdata_q <= rdata_q;
    end
  end

  // Byte-masked write port; array contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (we_s) begin
      for (int b = 0; b < 8; b++) begin
        if (wmask_s[b]) begin
          mem_q[waddr_s][8*b +: 8] <= auto_in_a_bits_data[8*b +: 8];
        end
      end
    end
  end

endmodule
